mc_control_fsm: RTL and testbench

- Main controller for the multi-cycle MIPS datapath. Sequences the shared ALU, the PC, the IR, the register file and the unified memory through the fetch, decode, execute, memory and writeback steps.
- Drives ALUSel using the existing ALU encoding: 010 add, 110 sub, 011 sll, 100 sllv, 101 srav.
- Stalls on a memory ready handshake.

---
 rtl/mc_control_if.sv | 34 +++
 rtl/mc_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master = controller (consumes IR fields/flags, drives control strobes); slave = datapath.
interface mc_control_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;

    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUSel;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal;
    logic [3:0] state_out;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUSel, PCSrc, PCEn, illegal, state_out
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUSel, PCSrc, PCEn, illegal, state_out
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main controller for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready stall handshake.
module mc_control_fsm #(
    parameter bit WAIT_STATES_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    state_t state_reg;
    state_t state_next;
    logic   mem_ok;
    logic   funct_ok;
    logic   op_ok;
    logic   pc_write;
    logic   branch;

    // With wait states disabled every memory access completes in one cycle.
    assign mem_ok = WAIT_STATES_EN ? bus.mem_ready : 1'b1;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.Funct)
            FN_ADD, FN_SUB, FN_SLL, FN_SLLV, FN_SRAV: funct_ok = 1'b1;
            default:                                  funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (bus.Op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            OP_R:                                op_ok = funct_ok;
            default:                             op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = funct_ok ? EXEC : FETCH;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: state_next = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_next = mem_ok ? MEMWB : MEMRD;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = mem_ok ? FETCH : MEMWR;
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            ADDIWB: state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Reset masks every output so no write strobe can fire while the machine is being cleared.
    always_comb begin
        bus.IorD      = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUSel    = reset ? 3'b000 : 3'b010;
        bus.PCSrc     = 2'b00;
        bus.PCEn      = 1'b0;
        bus.illegal   = 1'b0;
        bus.state_out = 4'd0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        if (!reset) begin
            bus.state_out = state_reg;
            case (state_reg)
                FETCH: begin
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = mem_ok;
                    pc_write    = mem_ok;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.illegal = ~op_ok;
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: bus.IorD = 1'b1;
                MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    case (bus.Funct)
                        FN_SUB:  bus.ALUSel = 3'b110;
                        FN_SLL:  bus.ALUSel = 3'b011;
                        FN_SLLV: bus.ALUSel = 3'b100;
                        FN_SRAV: bus.ALUSel = 3'b101;
                        default: bus.ALUSel = 3'b010;
                    endcase
                end
                ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSel  = 3'b110;
                    bus.PCSrc   = 2'b01;
                    branch      = 1'b1;
                end
                ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                ADDIWB: bus.RegWrite = 1'b1;
                JUMP: begin
                    bus.PCSrc = 2'b10;
                    pc_write  = 1'b1;
                end
                default: begin
                    bus.ALUSel    = 3'b000;
                    bus.state_out = 4'd0;
                end
            endcase
            bus.PCEn = pc_write | (branch & bus.Zero);
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its state
// sequence, exercises memory stalls, reset mid-store and illegal opcodes.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mc_control_if bus();

    mc_control_fsm #(.WAIT_STATES_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("chk  %s got=%0h exp=%0h ok", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] all_outs();
        return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUSel, bus.PCSrc,
                bus.PCEn, bus.illegal, bus.state_out};
    endfunction

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.Op    = op;
        bus.Funct = fn;
        #1;
    endtask

    initial begin
        bus.Op        = 6'd0;
        bus.Funct     = 6'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        reset         = 1'b1;

        // Reset held two cycles: every output must read 0.
        cyc();
        check("rst_c1_outs", 32'(all_outs()), 32'h0);
        cyc();
        check("rst_c2_outs", 32'(all_outs()), 32'h0);
        reset = 1'b0;
        #1;
        check("rel_state", 32'(bus.state_out), 32'd0);
        check("rel_irwrite", 32'(bus.IRWrite), 32'd1);
        check("rel_pcen", 32'(bus.PCEn), 32'd1);
        check("rel_alusrcb", 32'(bus.ALUSrcB), 32'b01);
        check("rel_alusel", 32'(bus.ALUSel), 32'b010);

        // lw: 0,1,2,3,4,0
        set_instr(6'b100011, 6'd0);
        check("lw_s0_iord", 32'(bus.IorD), 32'd0);
        cyc(); check("lw_s1", 32'(bus.state_out), 32'd1);
        check("lw_s1_alusrcb", 32'(bus.ALUSrcB), 32'b11);
        cyc(); check("lw_s2", 32'(bus.state_out), 32'd2);
        check("lw_s2_alusrcb", 32'(bus.ALUSrcB), 32'b10);
        check("lw_s2_iord", 32'(bus.IorD), 32'd0);
        cyc(); check("lw_s3", 32'(bus.state_out), 32'd3);
        check("lw_s3_iord", 32'(bus.IorD), 32'd1);
        cyc(); check("lw_s4", 32'(bus.state_out), 32'd4);
        check("lw_s4_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lw_s4_memtoreg", 32'(bus.MemtoReg), 32'd1);
        check("lw_s4_regdst", 32'(bus.RegDst), 32'd0);
        check("lw_s4_iord", 32'(bus.IorD), 32'd0);
        cyc(); check("lw_s0", 32'(bus.state_out), 32'd0);

        // R-type srav then sllv
        set_instr(6'b000000, 6'b000111);
        cyc(); check("srav_s1", 32'(bus.state_out), 32'd1);
        cyc(); check("srav_s6", 32'(bus.state_out), 32'd6);
        check("srav_alusel", 32'(bus.ALUSel), 32'b101);
        check("srav_alusrca", 32'(bus.ALUSrcA), 32'd1);
        cyc(); check("srav_s7", 32'(bus.state_out), 32'd7);
        check("srav_regwrite", 32'(bus.RegWrite), 32'd1);
        check("srav_regdst", 32'(bus.RegDst), 32'd1);
        cyc(); check("srav_s0", 32'(bus.state_out), 32'd0);
        set_instr(6'b000000, 6'b000100);
        cyc(); cyc();
        check("sllv_s6", 32'(bus.state_out), 32'd6);
        check("sllv_alusel", 32'(bus.ALUSel), 32'b100);
        cyc(); check("sllv_regwrite", 32'(bus.RegWrite), 32'd1);
        cyc(); check("sllv_s0", 32'(bus.state_out), 32'd0);

        // beq taken then not taken
        set_instr(6'b000100, 6'd0);
        bus.Zero = 1'b1;
        cyc(); cyc();
        #1;
        check("beq_t_s8", 32'(bus.state_out), 32'd8);
        check("beq_t_pcen", 32'(bus.PCEn), 32'd1);
        check("beq_t_pcsrc", 32'(bus.PCSrc), 32'b01);
        check("beq_t_alusel", 32'(bus.ALUSel), 32'b110);
        cyc(); check("beq_t_s0", 32'(bus.state_out), 32'd0);
        bus.Zero = 1'b0;
        cyc(); cyc();
        check("beq_n_s8", 32'(bus.state_out), 32'd8);
        check("beq_n_pcen", 32'(bus.PCEn), 32'd0);
        check("beq_n_alusel", 32'(bus.ALUSel), 32'b110);
        cyc(); check("beq_n_s0", 32'(bus.state_out), 32'd0);

        // j and addi
        set_instr(6'b000010, 6'd0);
        cyc(); cyc();
        check("j_s11", 32'(bus.state_out), 32'd11);
        check("j_pcen", 32'(bus.PCEn), 32'd1);
        check("j_pcsrc", 32'(bus.PCSrc), 32'b10);
        cyc(); check("j_s0", 32'(bus.state_out), 32'd0);
        set_instr(6'b001000, 6'd0);
        cyc(); cyc();
        check("addi_s9", 32'(bus.state_out), 32'd9);
        check("addi_alusrcb", 32'(bus.ALUSrcB), 32'b10);
        cyc(); check("addi_s10", 32'(bus.state_out), 32'd10);
        check("addi_regwrite", 32'(bus.RegWrite), 32'd1);
        check("addi_regdst", 32'(bus.RegDst), 32'd0);
        cyc(); check("addi_s0", 32'(bus.state_out), 32'd0);

        // Fetch stall: no IR/PC load until mem_ready
        bus.mem_ready = 1'b0;
        #1;
        check("fstall_irwrite", 32'(bus.IRWrite), 32'd0);
        check("fstall_pcen", 32'(bus.PCEn), 32'd0);
        cyc(); check("fstall_s0", 32'(bus.state_out), 32'd0);
        bus.mem_ready = 1'b1;

        // sw with 3 stall cycles in MEMWR
        set_instr(6'b101011, 6'd0);
        cyc(); cyc(); cyc();
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sw_stall%0d_s5", i), 32'(bus.state_out), 32'd5);
            check($sformatf("sw_stall%0d_memwrite", i), 32'(bus.MemWrite), 32'd1);
            check($sformatf("sw_stall%0d_regwrite", i), 32'(bus.RegWrite), 32'd0);
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("sw_last_memwrite", 32'(bus.MemWrite), 32'd1);
        check("sw_last_iord", 32'(bus.IorD), 32'd1);
        cyc(); check("sw_s0", 32'(bus.state_out), 32'd0);

        // Reset in the middle of a stalled store
        cyc(); cyc(); cyc();
        bus.mem_ready = 1'b0;
        #1;
        check("swr_s5", 32'(bus.state_out), 32'd5);
        cyc();
        reset = 1'b1;
        #1;
        check("swr_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        check("swr_after_s0", 32'(bus.state_out), 32'd0);
        check("swr_after_memwrite", 32'(bus.MemWrite), 32'd0);
        check("swr_after_irwrite", 32'(bus.IRWrite), 32'd0);
        bus.mem_ready = 1'b1;

        // Illegal opcode, then illegal funct
        set_instr(6'b111111, 6'd0);
        cyc(); check("ill_op_s1", 32'(bus.state_out), 32'd1);
        check("ill_op_flag", 32'(bus.illegal), 32'd1);
        check("ill_op_regwrite", 32'(bus.RegWrite), 32'd0);
        cyc(); check("ill_op_s0", 32'(bus.state_out), 32'd0);
        check("ill_op_flag_clr", 32'(bus.illegal), 32'd0);
        check("ill_op_rw0", 32'(bus.RegWrite), 32'd0);
        set_instr(6'b000000, 6'b101010);
        cyc(); check("ill_fn_s1", 32'(bus.state_out), 32'd1);
        check("ill_fn_flag", 32'(bus.illegal), 32'd1);
        cyc(); check("ill_fn_s0", 32'(bus.state_out), 32'd0);
        check("ill_fn_flag_clr", 32'(bus.illegal), 32'd0);
        check("ill_fn_regwrite", 32'(bus.RegWrite), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
